// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter: shares one SDRAM word port between a camera-side writer and a
// display-side reader, granting whole bursts round-robin and keeping a wrapping
// frame pointer per side.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no burst in flight; arbitrate pending requests
//   S_WRITE | write burst active, counting sd_ack beats
//   S_READ  | read burst active, counting sd_ack beats
module sdram_rw_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int BURST_LEN   = 8,
   parameter int FRAME_WORDS = 76800,
   parameter int WR_BASE     = 0,
   parameter int RD_BASE     = 0
) (
   input  logic              S_CLK,
   input  logic              RST,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic              frame_start,
   input  logic              sd_ack,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              sd_wr_en,
   output logic              sd_rd_en,
   output logic              wr_grant,
   output logic              rd_grant,
   output logic              wr_frame_done,
   output logic              rd_frame_done
);

   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] WR_BASE_A  = ADDR_W'(WR_BASE);
   localparam logic [ADDR_W-1:0] RD_BASE_A  = ADDR_W'(RD_BASE);
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              last_rd_q, last_rd_d;
   logic              fs_pend_q, fs_pend_d;
   logic              wr_grant_q, wr_grant_d;
   logic              rd_grant_q, rd_grant_d;
   logic              wr_done_q, wr_done_d;
   logic              rd_done_q, rd_done_d;
   logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
   logic              pick_wr, pick_rd;
   logic              burst_end;

   assign wr_ptr_inc = wr_ptr_q + BURST_STEP;
   assign rd_ptr_inc = rd_ptr_q + BURST_STEP;
   // On a tie the side not served last wins; last_rd_q resets to 1 so write wins first.
   assign pick_wr    = wr_req && (!rd_req || last_rd_q);
   assign pick_rd    = rd_req && (!wr_req || !last_rd_q);
   assign burst_end  = sd_ack && (beat_q == LAST_BEAT);

   // Next-state, pointer bookkeeping and registered pulse outputs.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      beat_d     = beat_q;
      last_rd_d  = last_rd_q;
      fs_pend_d  = fs_pend_q;
      wr_grant_d = 1'b0;
      rd_grant_d = 1'b0;
      wr_done_d  = 1'b0;
      rd_done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
            fs_pend_d = 1'b0;
            if (pick_wr) begin
               state_d    = S_WRITE;
               addr_d     = WR_BASE_A + (frame_start ? '0 : wr_ptr_q);
               wr_grant_d = 1'b1;
               last_rd_d  = 1'b0;
               beat_d     = '0;
            end else if (pick_rd) begin
               state_d    = S_READ;
               addr_d     = RD_BASE_A + (frame_start ? '0 : rd_ptr_q);
               rd_grant_d = 1'b1;
               last_rd_d  = 1'b1;
               beat_d     = '0;
            end
         end
         S_WRITE, S_READ: begin
            if (frame_start) fs_pend_d = 1'b1;
            if (sd_ack) beat_d = beat_q + 1'b1;
            if (burst_end) begin
               state_d = S_IDLE;
               beat_d  = '0;
               if (state_q == S_WRITE) begin
                  if (wr_ptr_inc == FRAME_END) begin
                     wr_ptr_d  = '0;
                     wr_done_d = 1'b1;
                  end else begin
                     wr_ptr_d = wr_ptr_inc;
                  end
               end else begin
                  if (rd_ptr_inc == FRAME_END) begin
                     rd_ptr_d  = '0;
                     rd_done_d = 1'b1;
                  end else begin
                     rd_ptr_d = rd_ptr_inc;
                  end
               end
               // A frame restart seen during the burst wins over the increment.
               if (fs_pend_q || frame_start) begin
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
               end
               fs_pend_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge S_CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         beat_q     <= '0;
         last_rd_q  <= 1'b1;
         fs_pend_q  <= 1'b0;
         wr_grant_q <= 1'b0;
         rd_grant_q <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         beat_q     <= beat_d;
         last_rd_q  <= last_rd_d;
         fs_pend_q  <= fs_pend_d;
         wr_grant_q <= wr_grant_d;
         rd_grant_q <= rd_grant_d;
         wr_done_q  <= wr_done_d;
         rd_done_q  <= rd_done_d;
      end
   end

   assign sd_addr       = addr_q;
   assign sd_wr_en      = (state_q == S_WRITE);
   assign sd_rd_en      = (state_q == S_READ);
   assign wr_grant      = wr_grant_q;
   assign rd_grant      = rd_grant_q;
   assign wr_frame_done = wr_done_q;
   assign rd_frame_done = rd_done_q;

endmodule
